bcd_counter_2dig: RTL
=====================

Name: bcd_counter_2dig

Overview:
- Two-digit BCD up/down counter datapath for the stopwatch.
- Consumes the control bundle from the stopwatch controller: reset, enable, up, and per-digit loads with load values.
- Returns the live digits q0 (units) and q1 (tens) to the controller and the display path.
- Contains the seconds prescaler, so counting advances once per tick, not once per clock.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count step; must be ≥2 (1 Hz at 50 MHz; benches use 4).
WRAP_EN, 1, 1 = wrap 99↔00; 0 = saturate at 99 (up) / 00 (down).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  1 = prescaler runs and digits step on tick; 0 = hold
up  input  1  1 = count up, 0 = count down; sampled on the tick cycle
load0  input  1  active-low synchronous load of units digit
load0_value  input  4  units load value
load1  input  1  active-low synchronous load of tens digit
load1_value  input  4  tens load value
q0  output  4  units digit, BCD 0–9
q1  output  4  tens digit, BCD 0–9
tick  output  1  one-cycle pulse, registered, high in the cycle a count step is taken
tc  output  1  combinational terminal count: up=1 and q=99, or up=0 and q=00

Behaviour:
- Reset (async, active-high): q0=0, q1=0, prescaler=0, tick=0. tc then reflects up (q=00 so tc=~up).
- Reset has priority over everything. Assertion mid-count clears immediately, without waiting for clk. After deassertion, counting resumes from 00 with a full TICK_DIV period.
- Prescaler, width clog2(TICK_DIV):
  - Increments each clk while enable=1; holds its value while enable=0 (pause/resume keeps phase).
  - When prescaler = TICK_DIV-1 and enable=1: prescaler goes to 0 and a step is taken this edge.
  - tick is registered high for the following cycle.
  - First step occurs TICK_DIV cycles after enable rises from reset.
- Up step (units first, carry to tens):
  - q0<9: q0+1.
  - q0=9: q0=0 and q1 increments.
  - q1=9 with carry: 99→00 if WRAP_EN=1; else hold 99.
- Down step:
  - q0>0: q0-1.
  - q0=0: q0=9 and q1 decrements.
  - 00 → 99 if WRAP_EN=1; else hold 00.
- Loads (active-low, synchronous, independent per digit):
  - Take effect on the next clk edge regardless of enable or tick.
  - Values 10–15 saturate to 9; never store a non-BCD code.
  - Load and step in the same cycle: load wins, and no step is applied to either digit that cycle (a lone load0 suppresses the tens carry too). The prescaler still advances/wraps normally and tick still pulses; the step is lost, not deferred.
- up change mid-period: the new direction applies at the next step only; the prescaler is not disturbed.
- enable=0: digits change only via load or reset; tick stays 0.
- Digits are always 0–9. Any out-of-range internal value (e.g. SEU) forces that digit to 0 on the next edge.

Test Plan (TICK_DIV=4, WRAP_EN=1 unless noted):
1. Reset, enable=1, up=1 → first tick 4 cycles after enable; q=01 after 1 step; q=10 after 10 steps; tick is exactly 1 cycle wide every 4 cycles.
2. Load q=98 (load0/load1 low, values 8/9), up=1, 2 steps → 99 with tc=1, then 00 with tc=0. Repeat with WRAP_EN=0 → holds 99, tc stays 1.
3. Load q=10, up=0 → steps give 09, 08. From 00 → 99 (WRAP_EN=1); holds 00 with tc=1 (WRAP_EN=0).
4. Count to 07; drop enable for 10 cycles → q holds 07, tick=0. Raise enable → next step occurs after the remaining prescaler count, not a fresh 4.
5. Assert load0 low with value 14 on a tick cycle while q=23 counting up → q=29: units saturated to 9, no step, tens unchanged.
6. Assert reset asynchronously between clk edges at q=57 → q=00 before the next edge. Release → first step 4 enabled cycles later.

Source files
------------

// File: rtl/bcd_counter_2dig.sv
// Two-digit BCD up/down counter with built-in tick prescaler.
// The digits step once per prescaler period. Per-digit active-low loads take
// priority over a step and cancel it. Out-of-range digit codes are scrubbed to 0.
module bcd_counter_2dig #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter bit          WRAP_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       up,
    input  logic       load0,
    input  logic [3:0] load0_value,
    input  logic       load1,
    input  logic [3:0] load1_value,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic       tick,
    output logic       tc
);

    localparam int unsigned     PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    q0_q, q0_d, q1_q, q1_d;
    logic          tick_q;
    logic          step;
    logic          load_any;
    logic          digits_ok;

    function automatic logic [3:0] bcd_sat(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Prescaler: runs only while enabled, so pausing keeps the phase.
    always_comb begin
        step  = enable && (pre_q >= PRE_MAX);
        pre_d = pre_q;
        if (enable) begin
            pre_d = step ? '0 : pre_q + PW'(1);
        end
    end

    // Digit next-state: loads win over a step, and a step is dropped if a load is present.
    always_comb begin
        load_any  = ~load0 | ~load1;
        digits_ok = (q0_q <= 4'd9) && (q1_q <= 4'd9);
        q0_d      = q0_q;
        q1_d      = q1_q;
        if (load_any) begin
            if (!load0) q0_d = bcd_sat(load0_value);
            if (!load1) q1_d = bcd_sat(load1_value);
        end else if (step && digits_ok) begin
            if (up) begin
                if (q0_q < 4'd9) begin
                    q0_d = q0_q + 4'd1;
                end else if (q1_q < 4'd9) begin
                    q0_d = 4'd0;
                    q1_d = q1_q + 4'd1;
                end else if (WRAP_EN) begin
                    q0_d = 4'd0;
                    q1_d = 4'd0;
                end
            end else begin
                if (q0_q > 4'd0) begin
                    q0_d = q0_q - 4'd1;
                end else if (q1_q > 4'd0) begin
                    q0_d = 4'd9;
                    q1_d = q1_q - 4'd1;
                end else if (WRAP_EN) begin
                    q0_d = 4'd9;
                    q1_d = 4'd9;
                end
            end
        end
        // Scrub corrupted digits that are not being reloaded this cycle
        if (load0 && (q0_q > 4'd9)) q0_d = 4'd0;
        if (load1 && (q1_q > 4'd9)) q1_d = 4'd0;
    end

    // State registers; tick is the registered step strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            q0_q   <= 4'd0;
            q1_q   <= 4'd0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            q0_q   <= q0_d;
            q1_q   <= q1_d;
            tick_q <= step;
        end
    end

    // Terminal count depends on the live direction.
    always_comb begin
        tc = up ? ((q1_q == 4'd9) && (q0_q == 4'd9)) : ((q1_q == 4'd0) && (q0_q == 4'd0));
    end

    assign q0   = q0_q;
    assign q1   = q1_q;
    assign tick = tick_q;

endmodule
